// File: rtl/threshold_buffer_loader.sv
`default_nettype none
// ============================================================================
// Module      : threshold_buffer_loader
// Description : Writer side of the run-time threshold store. A valid/ready
//               byte stream is packed MSB-first into DATA_WIDTH words and
//               written into an internal RAM of DATA_DEPTH words. The
//               accelerator reads the RAM via an enable/addr/data_o port
//               that returns registered data one cycle later.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: THRE_LOADER_CHECKSUM_EN
//   When defined, one trailing checksum byte (8-bit sum of all data bytes)
//   is consumed after the last word and load_err reports a mismatch.
//   When undefined, no checksum byte is consumed and load_err is 0.
// ----------------------------------------------------------------------------
// Ports:
//   clk        - clock, all logic on rising edge
//   rst        - synchronous active-high reset
//   load_start - one-cycle pulse starting a load at word 0
//   in_data    - stream byte
//   in_valid   - in_data valid
//   in_ready   - byte accepted when in_valid & in_ready
//   load_busy  - high while loading (LOAD or CHK)
//   load_done  - high after a complete load until next load_start / rst
//   load_err   - checksum mismatch flag
//   enable     - read enable
//   addr       - read address
//   data_o     - registered read data
// ============================================================================
module threshold_buffer_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BCW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int RAM_AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  // Holds the bytes of a word received before its final byte.
  localparam int PACK_W = (BYTES > 1) ? (DATA_WIDTH - 8) : 8;

  localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [RAM_AW-1:0]     LAST_WORD = RAM_AW'(DATA_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_A   = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CHK  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state_q,     state_d;
  logic [BCW-1:0]        byte_cnt_q,  byte_cnt_d;
  logic [RAM_AW-1:0]     word_cnt_q,  word_cnt_d;
  logic [PACK_W-1:0]     pack_q,      pack_d;
  logic                  load_done_q, load_done_d;
  logic [DATA_WIDTH-1:0] data_o_q,    data_o_d;

  logic                  accept;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] word_next;
  logic [PACK_W-1:0]     pack_shift;
  logic [RAM_AW-1:0]     rd_idx;

  // Storage is deliberately left out of reset so a reset mid-load keeps
  // the words already written.
  logic [DATA_WIDTH-1:0] ram [0:DATA_DEPTH-1];

  assign accept = in_valid & in_ready;
  assign rd_idx = addr[RAM_AW-1:0];

  // Byte packing: the completed word is the held bytes plus the current one.
  generate
    if (BYTES == 1) begin : g_pack_single
      assign word_next  = in_data;
      assign pack_shift = pack_q;
    end else if (BYTES == 2) begin : g_pack_two
      assign word_next  = {pack_q, in_data};
      assign pack_shift = in_data;
    end else begin : g_pack_multi
      assign word_next  = {pack_q, in_data};
      assign pack_shift = {pack_q[PACK_W-9:0], in_data};
    end
  endgenerate

`ifdef THRE_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       load_err_q, load_err_d;
`endif

  // --------------------------------------------------------------------------
  // State / datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      pack_q      <= '0;
      load_done_q <= 1'b0;
      data_o_q    <= '0;
`ifdef THRE_LOADER_CHECKSUM_EN
      sum_q       <= '0;
      load_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      pack_q      <= pack_d;
      load_done_q <= load_done_d;
      data_o_q    <= data_o_d;
`ifdef THRE_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      load_err_q  <= load_err_d;
`endif
    end
  end

  // RAM write port. The read above samples the pre-edge contents, giving
  // read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[word_cnt_q] <= word_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    pack_d      = pack_q;
    load_done_d = load_done_q;
    ram_we      = 1'b0;
`ifdef THRE_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    load_err_d  = load_err_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_start) begin
          state_d     = S_LOAD;
          byte_cnt_d  = '0;
          word_cnt_d  = '0;
          load_done_d = 1'b0;
`ifdef THRE_LOADER_CHECKSUM_EN
          sum_d       = '0;
          load_err_d  = 1'b0;
`endif
        end
      end

      S_LOAD: begin
        if (accept) begin
          pack_d = pack_shift;
`ifdef THRE_LOADER_CHECKSUM_EN
          sum_d  = sum_q + in_data;
`endif
          if (byte_cnt_q == LAST_BYTE) begin
            ram_we     = 1'b1;
            byte_cnt_d = '0;
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_q == LAST_WORD) begin
`ifdef THRE_LOADER_CHECKSUM_EN
              state_d     = S_CHK;
`else
              state_d     = S_DONE;
              load_done_d = 1'b1;
`endif
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      S_CHK: begin
`ifdef THRE_LOADER_CHECKSUM_EN
        if (accept) begin
          load_err_d  = (sum_q != in_data);
          load_done_d = 1'b1;
          state_d     = S_DONE;
        end
`else
        state_d = S_IDLE;
`endif
      end

      default: state_d = S_IDLE;
    endcase

    // Read port: hold when disabled, zero for out-of-range addresses.
    data_o_d = data_o_q;
    if (enable) begin
      if ({1'b0, addr} < DEPTH_A) begin
        data_o_d = ram[rd_idx];
      end else begin
        data_o_d = '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    load_busy = 1'b0;
    if ((state_q == S_LOAD) || (state_q == S_CHK)) begin
      in_ready  = 1'b1;
      load_busy = 1'b1;
    end
  end

  assign load_done = load_done_q;
  assign data_o    = data_o_q;
`ifdef THRE_LOADER_CHECKSUM_EN
  assign load_err  = load_err_q;
`else
  assign load_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_threshold_buffer_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_threshold_buffer_loader
// Description : Directed self-checking bench for threshold_buffer_loader
//               (default parameters: 8-bit address, 32-bit words, depth 2).
//               Honours THRE_LOADER_CHECKSUM_EN in the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_threshold_buffer_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic        enable = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] data_o;

  int total = 0;
  int bad   = 0;
  logic [7:0] tb_sum = 8'h00;

  threshold_buffer_loader #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .DATA_DEPTH(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .load_busy (load_busy),
    .load_done (load_done),
    .load_err  (load_err),
    .enable    (enable),
    .addr      (addr),
    .data_o    (data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
    tb_sum = 8'h00;
  endtask

  // Presents one byte and waits (bounded) until it is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $error("FAIL send_timeout observed=%h expected=%h", in_ready, 1'b1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    tb_sum = tb_sum + b;
  endtask

  task automatic read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    enable = 1'b1;
    addr   = a;
    @(posedge clk);
    #1 enable = 1'b0;
    check(tag, data_o, exp);
  endtask

  // Completes a load after its last data byte; bad_ck corrupts the checksum.
  task automatic finish_load(input logic bad_ck, input string tag);
`ifdef THRE_LOADER_CHECKSUM_EN
    check({tag, "_chk_busy"}, {31'd0, load_busy}, 32'd1);
    check({tag, "_chk_done"}, {31'd0, load_done}, 32'd0);
    send_byte(tb_sum + {7'd0, bad_ck});
    check({tag, "_err"}, {31'd0, load_err}, {31'd0, bad_ck});
`else
    check({tag, "_err"}, {31'd0, load_err}, 32'd0);
`endif
    check({tag, "_done"}, {31'd0, load_done}, 32'd1);
    check({tag, "_busy"}, {31'd0, load_busy}, 32'd0);
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {31'd0, in_ready},  32'd0);
    check("rst_busy",  {31'd0, load_busy}, 32'd0);
    check("rst_done",  {31'd0, load_done}, 32'd0);
    check("rst_err",   {31'd0, load_err},  32'd0);
    check("rst_data",  data_o,             32'd0);

    // Byte offered while idle is not taken
    in_valid = 1'b1;
    in_data  = 8'h99;
    @(negedge clk);
    check("idle_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;

    // Basic continuous load 01..08
    pulse_start();
    check("ld1_busy",  {31'd0, load_busy}, 32'd1);
    check("ld1_ready", {31'd0, in_ready},  32'd1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    finish_load(1'b0, "ld1");
    read(8'd0, 32'h01020304, "ld1_ram0");
    read(8'd1, 32'h05060708, "ld1_ram1");
    // Hold with enable low keeps last read value
    @(negedge clk);
    addr = 8'd0;
    repeat (2) @(negedge clk);
    check("hold_nonzero", data_o, 32'h05060708);
    read(8'd5, 32'h00000000, "oor_addr5");
    read(8'd255, 32'h00000000, "oor_addr255");
    repeat (2) @(negedge clk);
    check("hold_zero", data_o, 32'h00000000);
    check("done_stays", {31'd0, load_done}, 32'd1);

    // Toggled valid 11..18
    pulse_start();
    check("tg_done_clr", {31'd0, load_done}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h11 + 8'(i));
      if (i < 7) begin
        @(negedge clk);
        check("tg_ready_gap", {31'd0, in_ready}, 32'd1);
      end
    end
    finish_load(1'b0, "tg");
    read(8'd0, 32'h11121314, "tg_ram0");
    read(8'd1, 32'h15161718, "tg_ram1");

    // Reset after 5 bytes of 01..05
    pulse_start();
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_ready", {31'd0, in_ready},  32'd0);
    check("mr_busy",  {31'd0, load_busy}, 32'd0);
    check("mr_done",  {31'd0, load_done}, 32'd0);
    read(8'd0, 32'h01020304, "mr_ram0");
    read(8'd1, 32'h15161718, "mr_ram1_kept");

    // Reload AA..B1
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(8'hAA + 8'(i));
    finish_load(1'b0, "rl");
    read(8'd0, 32'hAAABACAD, "rl_ram0");
    read(8'd1, 32'hAEAFB0B1, "rl_ram1");

    // load_start mid-load ignored; also a same-address read during the
    // write of word 0 must return the old word.
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(8'h21 + 8'(i));
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
    check("ms_busy", {31'd0, load_busy}, 32'd1);
    @(negedge clk);
    in_data  = 8'h24;
    in_valid = 1'b1;
    enable   = 1'b1;
    addr     = 8'd0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    enable = 1'b0;
    tb_sum = tb_sum + 8'h24;
    check("rbw_old", data_o, 32'hAAABACAD);
    for (int i = 4; i < 8; i++) send_byte(8'h21 + 8'(i));
    finish_load(1'b0, "ms");
    read(8'd0, 32'h21222324, "ms_ram0");
    read(8'd1, 32'h25262728, "ms_ram1");

`ifdef THRE_LOADER_CHECKSUM_EN
    // Bad checksum: 01..08 followed by 0x25
    pulse_start();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    check("ck_sum_model", {24'd0, tb_sum}, 32'h24);
    finish_load(1'b1, "ckbad");
    pulse_start();
    check("ck_err_clr", {31'd0, load_err}, 32'd0);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    finish_load(1'b0, "ckgood");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
